// File: rtl/num_seq_chk.sv
// num_seq_chk
// Receive-side checker for the cyclic digit stream 2,0,1,7,0,3,0,1 (4-bit
// digits). Hunts for the alignment marker (2), qualifies lock over
// LOCK_FRAMES clean frames, then flywheels through the sequence, flagging
// and counting every mismatched digit while locked.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous, active-high reset
//   num        - received digit
//   num_vld    - num is sampled only when 1
//   err_clr    - synchronous clear of err_cnt (wins over an increment)
//   locked     - 1 while in LOCK
//   err        - one-cycle pulse: sampled digit mismatched in LOCK
//   frame_done - one-cycle pulse: position 7 sampled (VERIFY match / LOCK)
//   pos        - expected position of the next digit
//   err_cnt    - saturating count of LOCK-state mismatches
module num_seq_chk #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned LOSS_ERRS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  num,
    input  logic        num_vld,
    input  logic        err_clr,
    output logic        locked,
    output logic        err,
    output logic        frame_done,
    output logic [2:0]  pos,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [3:0] MARKER = 4'd2;
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic        fd_q, fd_d;
    logic [15:0] cnt_q, cnt_d;

    logic        match;
    logic [3:0]  good_inc;
    logic [3:0]  miss_inc;

    function automatic logic [3:0] exp_digit(input logic [2:0] p);
        case (p)
            3'd0:    exp_digit = 4'd2;
            3'd1:    exp_digit = 4'd0;
            3'd2:    exp_digit = 4'd1;
            3'd3:    exp_digit = 4'd7;
            3'd4:    exp_digit = 4'd0;
            3'd5:    exp_digit = 4'd3;
            3'd6:    exp_digit = 4'd0;
            default: exp_digit = 4'd1;
        endcase
    endfunction

    assign match    = (num == exp_digit(pos_q));
    assign good_inc = good_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        good_d   = good_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        fd_d     = 1'b0;

        if (num_vld) begin
            case (state_q)
                HUNT: begin
                    if (num == MARKER) begin
                        state_d = VERIFY;
                        pos_d   = 3'd1;
                        good_d  = '0;
                    end else begin
                        pos_d = '0;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        pos_d = pos_q + 3'd1;
                        if (pos_q == 3'd7) begin
                            good_d = good_inc;
                            fd_d   = 1'b1;
                            if (good_inc == LOCK_N) begin
                                state_d  = LOCK;
                                locked_d = 1'b1;
                                miss_d   = '0;
                            end
                        end
                    end else if (num == MARKER) begin
                        // A stray marker restarts qualification in place.
                        pos_d  = 3'd1;
                        good_d = '0;
                    end else begin
                        state_d = HUNT;
                        pos_d   = '0;
                        good_d  = '0;
                    end
                end
                LOCK: begin
                    pos_d = pos_q + 3'd1;
                    fd_d  = (pos_q == 3'd7);
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_inc;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        if (miss_inc == LOSS_N) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            pos_d    = '0;
                            good_d   = '0;
                            miss_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    pos_d    = '0;
                    good_d   = '0;
                    miss_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (err_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            fd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            fd_q     <= fd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign frame_done = fd_q;
    assign pos        = pos_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_num_seq_chk.sv
// Testbench for num_seq_chk: directed scenarios followed by random stimulus,
// every edge compared against a behavioural model of the checker's rules.
module tb_num_seq_chk;

    localparam int LOCK_FRAMES = 2;
    localparam int LOSS_ERRS   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  num = '0;
    logic        num_vld = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err;
    logic        frame_done;
    logic [2:0]  pos;
    logic [15:0] err_cnt;

    num_seq_chk #(
        .LOCK_FRAMES(LOCK_FRAMES),
        .LOSS_ERRS  (LOSS_ERRS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .num_vld   (num_vld),
        .err_clr   (err_clr),
        .locked    (locked),
        .err       (err),
        .frame_done(frame_done),
        .pos       (pos),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int tbl[8] = '{2, 0, 1, 7, 0, 3, 0, 1};

    // Model: mode 0 = hunting, 1 = qualifying, 2 = locked.
    int m_mode, m_pos, m_good, m_miss, m_cnt;
    int e_locked, e_err, e_fd;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    task automatic model(input int d, input bit v, input bit c, input bit r);
        if (r) begin
            m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_cnt = 0;
            e_err = 0; e_fd = 0;
        end else begin
            e_err = 0;
            e_fd  = 0;
            if (v) begin
                if (m_mode == 0) begin
                    if (d == 2) begin m_mode = 1; m_pos = 1; m_good = 0; end
                    else m_pos = 0;
                end else if (m_mode == 1) begin
                    if (d == tbl[m_pos]) begin
                        if (m_pos == 7) begin
                            m_good++;
                            e_fd = 1;
                            if (m_good == LOCK_FRAMES) begin m_mode = 2; m_miss = 0; end
                        end
                        m_pos = (m_pos + 1) % 8;
                    end else if (d == 2) begin
                        m_pos = 1; m_good = 0;
                    end else begin
                        m_mode = 0; m_pos = 0; m_good = 0;
                    end
                end else begin
                    e_fd = (m_pos == 7);
                    if (d == tbl[m_pos]) m_miss = 0;
                    else begin
                        e_err = 1;
                        if (m_cnt < 65535) m_cnt++;
                        m_miss++;
                    end
                    m_pos = (m_pos + 1) % 8;
                    if (m_miss == LOSS_ERRS) begin
                        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
                    end
                end
            end
            if (c) m_cnt = 0;
        end
        e_locked = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic step(input int d, input bit v, input bit c, input bit r);
        num = 4'(d); num_vld = v; err_clr = c; rst = r;
        @(posedge clk);
        model(d, v, c, r);
        #1;
        chk("locked", int'(locked), e_locked);
        chk("err", int'(err), e_err);
        chk("frame_done", int'(frame_done), e_fd);
        chk("pos", int'(pos), m_pos);
        chk("err_cnt", int'(err_cnt), m_cnt);
    endtask

    task automatic frame(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i], 1'b1, 1'b0, 1'b0);
            if (gaps) step(int'($urandom_range(15)), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int sp;
        int d;
        bit v;
        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_cnt = 0;
        e_locked = 0; e_err = 0; e_fd = 0;

        // Reset state
        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        // Clean stream: frame_done after samples 8 and 16, lock on the 16th
        for (int i = 0; i < 7; i++) step(tbl[i], 1'b1, 1'b0, 1'b0);
        step(tbl[7], 1'b1, 1'b0, 1'b0);
        chk("fd_s8", int'(frame_done), 1);
        chk("unlocked_s8", int'(locked), 0);
        for (int i = 0; i < 7; i++) step(tbl[i], 1'b1, 1'b0, 1'b0);
        chk("unlocked_s15", int'(locked), 0);
        step(tbl[7], 1'b1, 1'b0, 1'b0);
        chk("locked_s16", int'(locked), 1);
        chk("fd_s16", int'(frame_done), 1);

        // Same stream with gaps between digits
        step(0, 1'b0, 1'b0, 1'b1);
        frame(1'b1);
        frame(1'b1);
        chk("gap_locked", int'(locked), 1);
        chk("gap_cnt", int'(err_cnt), 0);

        // Single corrupted digit at pos 3 while locked
        for (int i = 0; i < 8; i++) step(i == 3 ? 5 : tbl[i], 1'b1, 1'b0, 1'b0);
        chk("single_err_cnt", int'(err_cnt), 1);
        chk("single_locked", int'(locked), 1);
        frame(1'b0);

        // Three consecutive bad digits drop lock, then re-lock after the next 2
        step(tbl[0], 1'b1, 1'b0, 1'b0);
        step(15, 1'b1, 1'b0, 1'b0);
        step(15, 1'b1, 1'b0, 1'b0);
        step(15, 1'b1, 1'b0, 1'b0);
        chk("loss_locked", int'(locked), 0);
        chk("loss_cnt", int'(err_cnt), 4);
        for (int i = 4; i < 8; i++) step(tbl[i], 1'b1, 1'b0, 1'b0);
        frame(1'b0);
        chk("relock_half", int'(locked), 0);
        frame(1'b0);
        chk("relock", int'(locked), 1);

        // Resync on a second marker during qualification
        step(0, 1'b0, 1'b0, 1'b1);
        step(2, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        step(2, 1'b1, 1'b0, 1'b0);
        chk("resync_pos", int'(pos), 1);
        for (int i = 1; i < 8; i++) step(tbl[i], 1'b1, 1'b0, 1'b0);
        chk("resync_fd", int'(frame_done), 1);
        frame(1'b0);
        chk("resync_locked", int'(locked), 1);

        // err_clr beats a simultaneous increment; a wrong 2 never resyncs
        step(5, 1'b1, 1'b0, 1'b0);
        step(2, 1'b1, 1'b1, 1'b0);
        chk("clr_err", int'(err), 1);
        chk("clr_cnt", int'(err_cnt), 0);
        chk("clr_locked", int'(locked), 1);

        // Reset while locked
        step(tbl[2], 1'b1, 1'b0, 1'b1);
        chk("rst2_locked", int'(locked), 0);
        chk("rst2_pos", int'(pos), 0);
        chk("rst2_cnt", int'(err_cnt), 0);

        // Random mostly-correct stream with corruption, gaps, clears, resets
        sp = 0;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(3) != 0);
            d = tbl[sp];
            if ($urandom_range(11) == 0) d = int'($urandom_range(15));
            if ($urandom_range(199) == 0) sp = int'($urandom_range(7));
            step(d, v, $urandom_range(63) == 0, $urandom_range(499) == 0);
            if (v) sp = (sp + 1) % 8;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
